// File: rtl/bamboo_pkg.sv
// Shared constants and types for the integer register file slice.
package bamboo_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_word_t;

endpackage

// File: rtl/regfile_pending_sb.sv
// Per-register pending scoreboard: issue marks a destination busy,
// writeback clears it, flush clears everything.
module regfile_pending_sb
    import bamboo_pkg::*;
#(
    parameter int NREGS    = bamboo_pkg::NREGS,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_we,
    input  logic [AW-1:0]    iss_addr,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_addr,
    input  logic             flush,
    output logic [NREGS-1:0] pending,
    output logic             any_busy
);

    logic iss_valid;
    logic wb_valid;

    // Register 0 never becomes pending when it is hardwired to zero.
    assign iss_valid = iss_we && !(ZERO_REG && (iss_addr == '0));
    assign wb_valid  = wb_we  && !(ZERO_REG && (wb_addr  == '0));

    // Flush beats issue beats writeback; the issue set is written last so a
    // same-address writeback cannot clear the younger instruction's mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            if (wb_valid) begin
                pending[wb_addr] <= 1'b0;
            end
            if (iss_valid) begin
                pending[iss_addr] <= 1'b1;
            end
        end
    end

    assign any_busy = |pending;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, one writeback
// port, optional write-to-read bypass and a pending-write scoreboard.
module regfile_sb
    import bamboo_pkg::*;
#(
    parameter int XLEN     = bamboo_pkg::XLEN,
    parameter int NREGS    = bamboo_pkg::NREGS,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                wb_we_i,
    input  logic [AW-1:0]       wb_addr_i,
    input  logic [XLEN-1:0]     wb_data_i,
    input  logic                iss_we_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                flush_i,
    output logic                any_busy_o
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic             wb_valid;
    logic             iss_live;

    assign wb_valid = wb_we_i  && !(ZERO_REG && (wb_addr_i  == '0));
    // An issue that survives this edge (not cancelled by a flush).
    assign iss_live = iss_we_i && !flush_i && !(ZERO_REG && (iss_addr_i == '0));

    regfile_pending_sb #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_pending (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_we   (iss_we_i),
        .iss_addr (iss_addr_i),
        .wb_we    (wb_we_i),
        .wb_addr  (wb_addr_i),
        .flush    (flush_i),
        .pending  (pending),
        .any_busy (any_busy_o)
    );

    // Data array: writeback lands on the edge; flush does not block it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            busy;
        logic            hit;

        assign addr = rd_addr_i[k*AW +: AW];
        // Bypass is suppressed in reset so outputs stay zero while rst_n is low.
        assign hit  = BYPASS && rst_n && wb_valid && (wb_addr_i == addr);

        // Read mux: zero register, then forwarded writeback, then array state.
        always_comb begin
            data = regs[addr];
            busy = pending[addr];
            if (ZERO_REG && (addr == '0)) begin
                data = '0;
                busy = 1'b0;
            end else if (hit) begin
                data = wb_data_i;
                busy = iss_live && (iss_addr_i == addr);
            end
        end

        assign rd_data_o[k*XLEN +: XLEN] = data;
        assign rd_busy_o[k]              = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb (bypass and no-bypass builds).
module tb_regfile_sb;
    import bamboo_pkg::*;

    localparam int NRD = 2;

    typedef struct {
        reg_addr_t  ra0;
        reg_addr_t  ra1;
        logic       wbWe;
        reg_addr_t  wbAddr;
        xlen_word_t wbData;
        logic       issWe;
        reg_addr_t  issAddr;
        logic       flush;
        xlen_word_t expD0;
        xlen_word_t expD1;
        logic       expB0;
        logic       expB1;
        logic       expAny;
    } vec_t;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NRD*REG_ADDR_W-1:0] rd_addr;
    logic [NRD*XLEN-1:0]       rd_data;
    logic [NRD*XLEN-1:0]       rd_data_nb;
    logic [NRD-1:0]            rd_busy;
    logic [NRD-1:0]            rd_busy_nb;
    logic                      wb_we;
    reg_addr_t                 wb_addr;
    xlen_word_t                wb_data;
    logic                      iss_we;
    reg_addr_t                 iss_addr;
    logic                      flush;
    logic                      any_busy;
    logic                      any_busy_nb;

    int total = 0;
    int bad   = 0;
    vec_t vecs [15];

    always #5 clk = ~clk;

    regfile_sb #(.NRD(NRD), .BYPASS(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_busy_o  (rd_busy),
        .wb_we_i    (wb_we),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .iss_we_i   (iss_we),
        .iss_addr_i (iss_addr),
        .flush_i    (flush),
        .any_busy_o (any_busy)
    );

    regfile_sb #(.NRD(NRD), .BYPASS(1'b0)) dutNb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data_nb),
        .rd_busy_o  (rd_busy_nb),
        .wb_we_i    (wb_we),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .iss_we_i   (iss_we),
        .iss_addr_i (iss_addr),
        .flush_i    (flush),
        .any_busy_o (any_busy_nb)
    );

    task automatic applyStimulus(input vec_t v);
        rd_addr  = {v.ra1, v.ra0};
        wb_we    = v.wbWe;
        wb_addr  = v.wbAddr;
        wb_data  = v.wbData;
        iss_we   = v.issWe;
        iss_addr = v.issAddr;
        flush    = v.flush;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        rd_addr  = '0;
        wb_we    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        iss_we   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic checkBypassDut(input string tag, input xlen_word_t d0, input xlen_word_t d1,
                                  input logic b0, input logic b1, input logic anyB);
        checkOutput({tag, ".d0"}, rd_data[31:0], d0);
        checkOutput({tag, ".d1"}, rd_data[63:32], d1);
        checkOutput({tag, ".b0"}, {31'd0, rd_busy[0]}, {31'd0, b0});
        checkOutput({tag, ".b1"}, {31'd0, rd_busy[1]}, {31'd0, b1});
        checkOutput({tag, ".any"}, {31'd0, any_busy}, {31'd0, anyB});
    endtask

    initial begin
        //           ra0 ra1 wbWe wbAddr wbData        issWe issAddr flush  expD0         expD1         b0 b1 any
        vecs[0]  = '{5'd5, 5'd31, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'd7, 5'd7,  1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{5'd7, 5'd5,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1};
        vecs[3]  = '{5'd7, 5'd7,  1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'd7, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'd3, 5'd3,  1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 1'b0, 32'h11,       32'h11,       1'b1, 1'b1, 1'b0};
        vecs[6]  = '{5'd3, 5'd7,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h11,       32'hDEADBEEF, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{5'd3, 5'd3,  1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 1'b1, 32'h11,       32'h11,       1'b0, 1'b0, 1'b1};
        vecs[8]  = '{5'd3, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h11,       32'h0,        1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'd0, 5'd0,  1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
        vecs[10] = '{5'd0, 5'd3,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h11,       1'b0, 1'b0, 1'b0};
        vecs[11] = '{5'd1, 5'd9,  1'b1, 5'd9, 32'h99,       1'b1, 5'd1, 1'b0, 32'h0,        32'h99,       1'b0, 1'b0, 1'b0};
        vecs[12] = '{5'd1, 5'd9,  1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b0, 32'h0,        32'h99,       1'b1, 1'b0, 1'b1};
        vecs[13] = '{5'd2, 5'd9,  1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0, 32'h0,        32'h99,       1'b1, 1'b0, 1'b1};
        vecs[14] = '{5'd1, 5'd9,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 32'h0,        32'h99,       1'b1, 1'b1, 1'b1};

        // Reset state, checked while reset is held and after release.
        idleInputs();
        rd_addr = {5'd31, 5'd5};
        rst_n   = 1'b0;
        #12;
        checkBypassDut("rst.hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkBypassDut("rst.rel", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Table: inputs applied mid-cycle, outputs checked before the next edge.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkBypassDut($sformatf("v%0d", i), vecs[i].expD0, vecs[i].expD1,
                           vecs[i].expB0, vecs[i].expB1, vecs[i].expAny);
        end

        // Asynchronous reset mid-cycle with r1, r2, r9 pending and r9 = 0x99.
        @(negedge clk);
        idleInputs();
        rd_addr = {5'd9, 5'd1};
        #2;
        rst_n = 1'b0;
        #1;
        checkBypassDut("arst", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("arst.nbAny", {31'd0, any_busy_nb}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkBypassDut("arst.rel", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Bypass-off build: same-cycle read sees the old value, then the new one.
        @(negedge clk);
        idleInputs();
        rd_addr = {5'd4, 5'd4};
        wb_we   = 1'b1;
        wb_addr = 5'd4;
        wb_data = 32'h5A;
        #1;
        checkOutput("nb.same.d0", rd_data_nb[31:0], 32'h0);
        checkOutput("nb.same.d1", rd_data_nb[63:32], 32'h0);
        checkOutput("byp.same.d0", rd_data[31:0], 32'h5A);
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        checkOutput("nb.next.d0", rd_data_nb[31:0], 32'h5A);

        // Bypass-off build keeps the pending bit visible until the edge.
        @(negedge clk);
        idleInputs();
        rd_addr  = {5'd6, 5'd6};
        iss_we   = 1'b1;
        iss_addr = 5'd6;
        @(negedge clk);
        iss_we  = 1'b0;
        wb_we   = 1'b1;
        wb_addr = 5'd6;
        wb_data = 32'h66;
        #1;
        checkOutput("nb.pend.b0", {31'd0, rd_busy_nb[0]}, 32'd1);
        checkOutput("nb.pend.d0", rd_data_nb[31:0], 32'h0);
        checkOutput("byp.pend.b0", {31'd0, rd_busy[0]}, 32'd0);
        checkOutput("byp.pend.d0", rd_data[31:0], 32'h66);
        @(negedge clk);
        wb_we = 1'b0;
        #1;
        checkOutput("nb.clr.b0", {31'd0, rd_busy_nb[0]}, 32'd0);
        checkOutput("nb.clr.any", {31'd0, any_busy_nb}, 32'd0);
        checkOutput("nb.clr.d0", rd_data_nb[31:0], 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
